// File: rtl/reg_ctx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctx_ctrl
// Description : Register-context save/restore engine. Dumps the 32-entry
//               register file to a memory context area or reloads it, one
//               word per access, stalling the CPU through BUSY.
//               Optional build macro REG_CTX_SKIP_X0_EN starts at register 1
//               so that x0 is never transferred.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_ctx_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SAVE_REQ,
    input  logic        RESTORE_REQ,
    input  logic [31:0] BASE_ADDR,
    output logic        BUSY,
    output logic        DONE,
    output logic [4:0]  RF_RADDR,
    input  logic [31:0] RF_RDATA,
    output logic [4:0]  RF_WADDR,
    output logic [31:0] RF_WDATA,
    output logic        RF_WRITE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

`ifdef REG_CTX_SKIP_X0_EN
    localparam logic [4:0] START_IDX = 5'd1;
`else
    localparam logic [4:0] START_IDX = 5'd0;
`endif
    localparam logic [4:0] LAST_IDX = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SAVE_FETCH  = 3'd1,
        S_SAVE_WRITE  = 3'd2,
        S_LOAD_READ   = 3'd3,
        S_LOAD_COMMIT = 3'd4,
        S_FINISH      = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q,   idx_d;
    logic [31:0] data_q,  data_d;
    logic [31:0] base_q,  base_d;
    logic [31:0] word_addr;

    // Context-area address of the current register; wraps modulo 2^32.
    assign word_addr = base_q + {25'd0, idx_q, 2'b00};

    // State, index, data and base registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            data_q  <= 32'd0;
            base_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            base_q  <= base_d;
        end
    end

    // Next-state and output decode; every output is zero in IDLE.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        data_d        = data_q;
        base_d        = base_q;
        BUSY          = (state_q != S_IDLE);
        DONE          = 1'b0;
        RF_RADDR      = 5'd0;
        RF_WADDR      = 5'd0;
        RF_WDATA      = 32'd0;
        RF_WRITE      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDR      = 32'd0;
        MEM_WRITEDATA = 32'd0;

        case (state_q)
            S_IDLE: begin
                // Save has priority when both requests are present.
                if (SAVE_REQ) begin
                    base_d  = BASE_ADDR & 32'hFFFF_FFFC;
                    idx_d   = START_IDX;
                    state_d = S_SAVE_FETCH;
                end else if (RESTORE_REQ) begin
                    base_d  = BASE_ADDR & 32'hFFFF_FFFC;
                    idx_d   = START_IDX;
                    state_d = S_LOAD_READ;
                end
            end
            S_SAVE_FETCH: begin
                RF_RADDR = idx_q;
                data_d   = RF_RDATA;
                state_d  = S_SAVE_WRITE;
            end
            S_SAVE_WRITE: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDR      = word_addr;
                MEM_WRITEDATA = data_q;
                if (!MEM_BUSYWAIT) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_SAVE_FETCH;
                    end
                end
            end
            S_LOAD_READ: begin
                MEM_READ = 1'b1;
                MEM_ADDR = word_addr;
                if (!MEM_BUSYWAIT) begin
                    data_d  = MEM_READDATA;
                    state_d = S_LOAD_COMMIT;
                end
            end
            S_LOAD_COMMIT: begin
                RF_WRITE = 1'b1;
                RF_WADDR = idx_q;
                RF_WDATA = data_q;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_LOAD_READ;
                end
            end
            S_FINISH: begin
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/reg_ctx_ctrl.md
REG_CTX_CTRL -- requirements
Module: reg_ctx_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK in 1, rising-edge clock; RESET in 1, asynchronous active-low reset.
REQ-002 The block SHALL have a start-save input: SAVE_REQ in 1, a level request to dump all registers to memory.
REQ-003 The block SHALL have a start-restore input: RESTORE_REQ in 1, a level request to load all registers from memory.
REQ-004 The block SHALL have a base-address input: BASE_ADDR in 32, the context area base address, latched at request accept; bits [1:0] are treated as 0.
REQ-005 The block SHALL have status outputs: BUSY out 1, high in every state except IDLE, and also used as the CPU stall; DONE out 1, a one-cycle completion pulse.
REQ-006 The block SHALL have register-file read outputs and input: RF_RADDR out 5, the read-port address; RF_RDATA in 32, the read-port data.
REQ-007 The block SHALL have register-file write outputs: RF_WADDR out 5, RF_WDATA out 32, and RF_WRITE out 1, the write strobe.
REQ-008 The block SHALL have memory strobe outputs: MEM_READ out 1 and MEM_WRITE out 1, the memory strobes.
REQ-009 The block SHALL have memory address and data outputs: MEM_ADDR out 32, the word address; MEM_WRITEDATA out 32, the store data.
REQ-010 The block SHALL have memory inputs: MEM_READDATA in 32, the load data; MEM_BUSYWAIT in 1, high while memory is not ready.

Function
REQ-011 The block SHALL have states IDLE, SAVE_FETCH, SAVE_WRITE, LOAD_READ, LOAD_COMMIT and FINISH, with a 5-bit index register IDX.
REQ-012 In IDLE, if SAVE_REQ is high, the block SHALL latch BASE_ADDR, set IDX to the start index and go to SAVE_FETCH; otherwise, if RESTORE_REQ is high, it SHALL do the same but go to LOAD_READ.
REQ-013 When SAVE_REQ and RESTORE_REQ are both high in IDLE, save SHALL win.
REQ-014 Requests arriving in any non-IDLE state SHALL be ignored and not queued.
REQ-015 In SAVE_FETCH, the block SHALL drive RF_RADDR=IDX, capture RF_RDATA into a data register at the edge, and go to SAVE_WRITE; this state lasts exactly one cycle.
REQ-016 In SAVE_WRITE, the block SHALL hold MEM_WRITE=1, MEM_ADDR=base+4*IDX and MEM_WRITEDATA=the data register stable.
REQ-017 SAVE_WRITE SHALL complete at the first rising edge with MEM_BUSYWAIT=0: if IDX=31 the block goes to FINISH; otherwise IDX increments and the block goes to SAVE_FETCH.
REQ-018 In LOAD_READ, the block SHALL hold MEM_READ=1 and MEM_ADDR=base+4*IDX, and at the first edge with MEM_BUSYWAIT=0 capture MEM_READDATA into the data register and go to LOAD_COMMIT.
REQ-019 In LOAD_COMMIT, the block SHALL drive RF_WRITE=1, RF_WADDR=IDX and RF_WDATA=the data register for exactly one cycle; if IDX=31 it goes to FINISH, otherwise IDX increments and it goes to LOAD_READ.
REQ-020 In FINISH, the block SHALL assert DONE=1 for one cycle and return to IDLE.
REQ-021 MEM_READ, MEM_WRITE and RF_WRITE SHALL never be high in the same cycle.
REQ-022 Strobes SHALL be 0 outside their owning states.
REQ-023 Address arithmetic SHALL be modulo 2^32 and wrap silently.
REQ-024 With zero-wait memory, a full save SHALL take 64 cycles plus 1 FINISH cycle, and a full restore the same.
REQ-025 Each busywait cycle SHALL add exactly one cycle to the operation.

Reset
REQ-026 When RESET is low, the block SHALL immediately force IDLE, IDX=0, the data register=0, the latched base=0, and all outputs to 0, including BUSY, DONE, strobes, addresses and data.
REQ-027 A reset in mid-operation SHALL abort without a DONE pulse; registers and memory already written are left as written.
REQ-028 After RESET returns high, the first request SHALL be accepted on the next rising edge.

Configuration
REQ-029 When macro REG_CTX_SKIP_X0_EN is defined, the start index SHALL be 1, register 0 is never read, written or transferred, and a full save or restore moves 31 words (62+1 cycles at zero wait).
REQ-030 When REG_CTX_SKIP_X0_EN is not defined, the start index SHALL be 0 and all 32 registers are transferred.

Verification
REQ-031 Scenario: RF preloaded with Rn=0x1000+n, BASE_ADDR=0x200, SAVE_REQ pulse, zero-wait memory -> writes at 0x200..0x27C carrying 0x1000..0x101F, DONE at cycle 65 and BUSY high for cycles 1-65.
REQ-032 Scenario: memory word i=0xA5000000+i, RESTORE_REQ -> 32 RF writes with RF_WADDR 0..31 and matching data, DONE once, never MEM_WRITE.
REQ-033 Scenario: MEM_BUSYWAIT held high 3 cycles on every access during a save -> total time 32*(1+4)+1=161 cycles with correct data.
REQ-034 Scenario: SAVE_REQ and RESTORE_REQ high together -> save performed; a RESTORE_REQ raised during the save is ignored and DONE pulses exactly once.
REQ-035 Scenario: RESET driven low at IDX=10 of a restore, asynchronous to CLK -> outputs 0 immediately and no DONE; a following save starts cleanly at IDX 0.
REQ-036 Scenario: REG_CTX_SKIP_X0_EN defined, save with BASE_ADDR=0xFFFFFFF8 -> first access at 0xFFFFFFFC for register 1, address wraps to 0x00000000 for register 2, 31 writes and DONE at cycle 63.
